// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file's single write port between load return (port 0)
// and ALU writeback (port 1), registers the winning write, and flags read forwarding.
module rf_wb_arbiter #(
  parameter int addr_width_p = 6,
  parameter int data_width_p = 32,
  parameter int max_wait_p   = 3
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    v0_i,
  input  logic [addr_width_p-1:0] addr0_i,
  input  logic [data_width_p-1:0] data0_i,
  output logic                    ready0_o,
  input  logic                    v1_i,
  input  logic [addr_width_p-1:0] addr1_i,
  input  logic [data_width_p-1:0] data1_i,
  output logic                    ready1_o,
  output logic                    rf_wen_o,
  output logic [addr_width_p-1:0] rf_wa_o,
  output logic [data_width_p-1:0] rf_wd_o,
  input  logic [addr_width_p-1:0] rs_addr_i,
  output logic                    fwd_v_o,
  output logic [data_width_p-1:0] fwd_data_o,
  output logic                    starve_o
);

  localparam logic [3:0] max_wait_lp = 4'(max_wait_p);

  logic [3:0] starve_cnt;
  logic       force_p1;
  logic       xfer;

  assign force_p1 = (starve_cnt == max_wait_lp);
  assign starve_o = force_p1;

  // Port 0 has priority unless port 1 has lost max_wait_p times in a row.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    ready0_o = 1'b0;
    ready1_o = 1'b0;
    if (reset_n_i) begin
      if (force_p1 && v1_i)  ready1_o = 1'b1;
      else if (v0_i)         ready0_o = 1'b1;
      else if (v1_i)         ready1_o = 1'b1;
    end
  end

  assign xfer = ready0_o | ready1_o;

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n_i) begin
      starve_cnt <= '0;
      rf_wen_o   <= 1'b0;
      rf_wa_o    <= '0;
      rf_wd_o    <= '0;
    end else begin
      if (v1_i && !ready1_o)
        starve_cnt <= force_p1 ? starve_cnt : starve_cnt + 4'd1;
      else
        starve_cnt <= '0;

      rf_wen_o <= xfer;
      // Address and data hold on idle cycles; only rf_wen_o marks a new write.
      if (ready0_o) begin
        rf_wa_o <= addr0_i;
        rf_wd_o <= data0_i;
      end else if (ready1_o) begin
        rf_wa_o <= addr1_i;
        rf_wd_o <= data1_i;
      end
    end
  end

  assign fwd_v_o    = rf_wen_o && (rs_addr_i == rf_wa_o);
  assign fwd_data_o = rf_wd_o;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed test-plan steps followed by
// randomized requesters compared against a behavioural model of the write port.
module tb_rf_wb_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          v0_i, v1_i;
  logic [AW-1:0] addr0_i, addr1_i, rs_addr_i;
  logic [DW-1:0] data0_i, data1_i;
  logic          ready0_o, ready1_o, rf_wen_o, fwd_v_o, starve_o;
  logic [AW-1:0] rf_wa_o;
  logic [DW-1:0] rf_wd_o, fwd_data_o;

  rf_wb_arbiter #(.addr_width_p(AW), .data_width_p(DW), .max_wait_p(MW)) dut (
    .clk(clk), .reset_n_i(reset_n_i),
    .v0_i(v0_i), .addr0_i(addr0_i), .data0_i(data0_i), .ready0_o(ready0_o),
    .v1_i(v1_i), .addr1_i(addr1_i), .data1_i(data1_i), .ready1_o(ready1_o),
    .rf_wen_o(rf_wen_o), .rf_wa_o(rf_wa_o), .rf_wd_o(rf_wd_o),
    .rs_addr_i(rs_addr_i), .fwd_v_o(fwd_v_o), .fwd_data_o(fwd_data_o),
    .starve_o(starve_o)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: the pending write port contents and port 1's current losing streak.
  logic          m_wen;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int            m_streak;

  // DUT values captured at the last step's check point.
  logic          obs_r0, obs_r1, obs_wen, obs_starve;
  logic [AW-1:0] obs_wa;
  logic [DW-1:0] obs_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_grant(output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset_n_i) begin
      if (v1_i && m_streak == MW) g1 = 1'b1;
      else if (v0_i)              g0 = 1'b1;
      else if (v1_i)              g1 = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic g0, g1;
    model_grant(g0, g1);
    obs_r0 = ready0_o;  obs_r1 = ready1_o;  obs_wen = rf_wen_o;
    obs_wa = rf_wa_o;   obs_wd = rf_wd_o;   obs_starve = starve_o;
    check({tag, ".ready0"}, 64'(ready0_o), 64'(g0));
    check({tag, ".ready1"}, 64'(ready1_o), 64'(g1));
    check({tag, ".wen"}, 64'(rf_wen_o), 64'(m_wen));
    check({tag, ".wa"}, 64'(rf_wa_o), 64'(m_wa));
    check({tag, ".wd"}, 64'(rf_wd_o), 64'(m_wd));
    check({tag, ".fwd_v"}, 64'(fwd_v_o), 64'(m_wen && rs_addr_i == m_wa));
    check({tag, ".fwd_data"}, 64'(fwd_data_o), 64'(m_wd));
    check({tag, ".starve"}, 64'(starve_o), 64'(m_streak == MW));
  endtask

  // Advance the model across a rising edge using the inputs held during that cycle.
  task automatic model_tick();
    logic g0, g1;
    model_grant(g0, g1);
    if (!reset_n_i) begin
      m_wen = 1'b0; m_wa = '0; m_wd = '0; m_streak = 0;
    end else begin
      m_wen = g0 | g1;
      if (g0)      begin m_wa = addr0_i; m_wd = data0_i; end
      else if (g1) begin m_wa = addr1_i; m_wd = data1_i; end
      if (v1_i && !g1) m_streak = (m_streak < MW) ? m_streak + 1 : MW;
      else             m_streak = 0;
    end
  endtask

  task automatic step(input string tag, input logic rst,
                      input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic [AW-1:0] rs);
    @(negedge clk);
    reset_n_i = rst;
    v0_i = v0; addr0_i = a0; data0_i = d0;
    v1_i = v1; addr1_i = a1; data1_i = d1;
    rs_addr_i = rs;
    #1;
    check_all(tag);
    @(posedge clk);
    model_tick();
  endtask

  initial begin
    logic          p0, p1, rst;
    logic [AW-1:0] pa0, pa1, rs;
    logic [DW-1:0] pd0, pd1;

    reset_n_i = 1'b0;
    v0_i = 1'b1; v1_i = 1'b1;
    addr0_i = 6'd1; addr1_i = 6'd2; data0_i = '0; data1_i = '0; rs_addr_i = '0;
    m_wen = 1'b0; m_wa = '0; m_wd = '0; m_streak = 0;
    @(posedge clk);
    model_tick();

    // Reset held with both requesters valid, then released.
    step("rst0", 1'b0, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 6'd0);
    check("rst0.no_grant", 64'(obs_r0 | obs_r1), 64'd0);
    step("rst1", 1'b0, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 6'd0);
    check("rst1.wen", 64'(obs_wen), 64'd0);
    step("rel", 1'b1, 1'b1, 6'd1, 32'h11, 1'b1, 6'd2, 32'h22, 6'd0);
    check("rel.ready0", 64'(obs_r0), 64'd1);

    // Single port-1 write.
    step("sw0", 1'b1, 1'b0, 6'd0, 32'h0, 1'b1, 6'd5, 32'hDEADBEEF, 6'd0);
    check("sw0.ready1", 64'(obs_r1), 64'd1);
    step("sw1", 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd5);
    check("sw1.wen", 64'(obs_wen), 64'd1);
    check("sw1.wa", 64'(obs_wa), 64'd5);
    check("sw1.wd", 64'(obs_wd), 64'hDEADBEEF);
    step("sw2", 1'b1, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0, 32'h0, 6'd5);
    check("sw2.wen", 64'(obs_wen), 64'd0);

    // Continuous contention: grant pattern 0,0,0,1 repeating.
    for (int i = 0; i < 8; i++) begin
      step("cont", 1'b1, 1'b1, 6'(10 + i), 32'(i), 1'b1, 6'd20, 32'h99, 6'd0);
      check($sformatf("cont%0d.grant1", i), 64'(obs_r1), 64'(i % 4 == 3));
      check($sformatf("cont%0d.starve", i), 64'(obs_starve), 64'(i % 4 == 3));
    end

    // Back-to-back port-0 writes to 1,2,3.
    step("b2b0", 1'b1, 1'b1, 6'd1, 32'hA1, 1'b0, 6'd0, 32'h0, 6'd0);
    for (int i = 1; i <= 3; i++) begin
      step("b2b", 1'b1, (i < 3), 6'(i + 1), 32'(i), 1'b0, 6'd0, 32'h0, 6'd0);
      check($sformatf("b2b%0d.wen", i), 64'(obs_wen), 64'd1);
      check($sformatf("b2b%0d.wa", i), 64'(obs_wa), 64'(i));
    end

    // Forwarding against an in-flight write to register 7.
    step("fw0", 1'b1, 1'b1, 6'd7, 32'h1234, 1'b0, 6'd0, 32'h0, 6'd0);
    @(negedge clk);
    v0_i = 1'b0; v1_i = 1'b0; rs_addr_i = 6'd7;
    #1;
    check("fw.hit_v", 64'(fwd_v_o), 64'd1);
    check("fw.hit_data", 64'(fwd_data_o), 64'h1234);
    rs_addr_i = 6'd8;
    #1;
    check("fw.miss_v", 64'(fwd_v_o), 64'd0);
    @(posedge clk);
    model_tick();

    // Mid-stream reset: accepted write is followed by reset; no write emerges afterwards.
    step("mr0", 1'b1, 1'b1, 6'd9, 32'h5A5A, 1'b1, 6'd9, 32'hA5A5, 6'd9);
    check("mr0.ready0", 64'(obs_r0), 64'd1);
    step("mr1", 1'b0, 1'b1, 6'd9, 32'h7777, 1'b1, 6'd9, 32'hA5A5, 6'd9);
    check("mr1.no_grant", 64'(obs_r0 | obs_r1), 64'd0);
    step("mr2", 1'b0, 1'b1, 6'd9, 32'h7777, 1'b1, 6'd9, 32'hA5A5, 6'd9);
    check("mr2.wen", 64'(obs_wen), 64'd0);
    check("mr2.starve", 64'(obs_starve), 64'd0);

    // Randomized requesters that hold each request until it is accepted.
    p0 = 1'b0; p1 = 1'b0;
    pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 3) != 0) begin
        p0 = 1'b1; pa0 = 6'($urandom_range(0, 7)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 3) != 0) begin
        p1 = 1'b1; pa1 = 6'($urandom_range(0, 7)); pd1 = $urandom;
      end
      rst = ($urandom_range(0, 49) != 0);
      rs  = ($urandom_range(0, 1) == 1) ? m_wa : 6'($urandom_range(0, 7));
      step("rnd", rst, p0, pa0, pd0, p1, pa1, pd1, rs);
      if (obs_r0) p0 = 1'b0;
      if (obs_r1) p1 = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
